// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_pkg
// Brief   : State encoding and default widths shared by the RAM arbiter,
//           the RAM and depp_mem.
// Revision: 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_OWN0 = ST_OWN0,
      S_OWN1 = ST_OWN1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arb_hold_cnt.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb_hold_cnt
// Brief   : Saturating access counter with synchronous clear (clear wins).
// Revision: 1.0 - initial release
// ============================================================================
module ram_arb_hold_cnt #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [HOLD_W-1:0] cnt_o
);

   localparam logic [HOLD_W-1:0] CNT_MAX = HOLD_W'(MAX_HOLD);

   logic [HOLD_W-1:0] cnt_q;
   logic [HOLD_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Brief   : Two-requester arbiter for a single-port registered-read RAM with a
//           bounded hold per grant. RAM_ARB_RR_EN selects round-robin ties.
// Revision: 1.0 - initial release
// ============================================================================
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_HOLD   = 16,
   parameter int HOLD_W     = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   state_t            state_q;
   logic              last_owner_q;
   logic              m0_rvalid_q;
   logic              m1_rvalid_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [HOLD_W:0]   hold_sum;
   logic              own_req;
   logic              hold_reach;
   logic              release_own;
   logic              tie_to_m1;

   assign own_req    = ((state_q == S_OWN0) && m0_req) || ((state_q == S_OWN1) && m1_req);
   assign hold_sum   = {1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, own_req};
   assign hold_reach = (hold_sum >= (HOLD_W + 1)'(MAX_HOLD));

`ifdef RAM_ARB_RR_EN
   assign tie_to_m1 = ~last_owner_q;
`else
   // Ties are fixed-priority to m0; the owner history is only kept.
   assign tie_to_m1 = last_owner_q & 1'b0;
`endif

   always_comb begin
      m0_ack      = 1'b0;
      m1_ack      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_din     = '0;
      release_own = 1'b0;
      case (state_q)
         S_OWN0: begin
            if (m0_req) begin
               m0_ack   = 1'b1;
               ram_we   = m0_we;
               ram_addr = m0_addr;
               ram_din  = m0_wdata;
            end
            release_own = ~m0_req | (m1_req & hold_reach);
         end
         S_OWN1: begin
            if (m1_req) begin
               m1_ack   = 1'b1;
               ram_we   = m1_we;
               ram_addr = m1_addr;
               ram_din  = m1_wdata;
            end
            release_own = ~m1_req | (m0_req & hold_reach);
         end
         default: begin
            release_own = 1'b0;
         end
      endcase
   end

   ram_arb_hold_cnt #(
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) u_hold_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (release_own || (state_q == S_IDLE)),
      .inc_i (own_req),
      .cnt_o (hold_cnt_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_owner_q <= 1'b1;
         m0_rvalid_q  <= 1'b0;
         m1_rvalid_q  <= 1'b0;
      end else begin
         m0_rvalid_q <= m0_ack & ~m0_we;
         m1_rvalid_q <= m1_ack & ~m1_we;
         case (state_q)
            S_IDLE: begin
               if (m0_req && m1_req) begin
                  state_q <= tie_to_m1 ? S_OWN1 : S_OWN0;
               end else if (m0_req) begin
                  state_q <= S_OWN0;
               end else if (m1_req) begin
                  state_q <= S_OWN1;
               end
            end
            S_OWN0: begin
               if (release_own) begin
                  last_owner_q <= 1'b0;
                  state_q      <= m1_req ? S_OWN1 : S_IDLE;
               end
            end
            S_OWN1: begin
               if (release_own) begin
                  last_owner_q <= 1'b1;
                  state_q      <= m0_req ? S_OWN0 : S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rvalid_q ? ram_dout : '0;
   assign m1_rdata  = m1_rvalid_q ? ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_arbiter
// Brief   : Directed bench with a behavioural RAM and arbitration model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   localparam int MAXH = 16;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } op_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m0_req, m0_we, m1_req, m1_we;
   logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic       m0_ack, m0_rvalid, m1_ack, m1_rvalid, ram_we;
   logic [7:0] m0_rdata, m1_rdata, ram_addr, ram_din;
   logic [7:0] ram_dout = 8'h00;
   logic [7:0] mem [256] = '{default: 8'h00};

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   op_t q0[$];
   op_t q1[$];
   int  log_who[$];
   int  log_cyc[$];
   int  runs_who[$], runs_len[$], runs_start[$], runs_end[$];

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(MAXH), .HOLD_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Write-first RAM with one-cycle registered read.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= ram_we ? ram_din : mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out, expected DUT progress (t=%0t)", name, $time);
   endtask

   function automatic op_t mk(input logic we, input logic [7:0] a, input logic [7:0] d);
      op_t o;
      o.we = we; o.addr = a; o.data = d;
      return o;
   endfunction

   // Requesters: present the queue head, advance only after an ack.
   initial begin : driver
      bit a0, a1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      forever begin
         @(negedge clk);
         a0 = m0_ack;
         a1 = m1_ack;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            q0.delete();
            q1.delete();
         end else begin
            if (a0 && q0.size() != 0) void'(q0.pop_front());
            if (a1 && q1.size() != 0) void'(q1.pop_front());
         end
         m0_req = (q0.size() != 0);
         m1_req = (q1.size() != 0);
         {m0_we, m0_addr, m0_wdata} = m0_req ? q0[0] : 17'd0;
         {m1_we, m1_addr, m1_wdata} = m1_req ? q1[0] : 17'd0;
      end
   end

   // Behavioural model: who owns the RAM, how many accesses it has had,
   // and which reads are still to come back.
   initial begin : model
      int         own, served, last, oth;
      bit         r [2];
      bit         w [2];
      bit         ea [2];
      bit         pv [2];
      logic [7:0] pd [2];
      logic [7:0] ad [2];
      logic [7:0] wd [2];
      logic [7:0] bmem [256];
      logic       e_we;
      logic [7:0] e_addr, e_din;
      for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
      own = -1; served = 0; last = 1;
      pv[0] = 0; pv[1] = 0; pd[0] = 0; pd[1] = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            own = -1; served = 0; last = 1;
            pv[0] = 0; pv[1] = 0;
         end else begin
            cyc++;
            r[0] = m0_req; w[0] = m0_we; ad[0] = m0_addr; wd[0] = m0_wdata;
            r[1] = m1_req; w[1] = m1_we; ad[1] = m1_addr; wd[1] = m1_wdata;
            ea[0] = (own == 0) && r[0];
            ea[1] = (own == 1) && r[1];
            e_we = 0; e_addr = 0; e_din = 0;
            for (int k = 0; k < 2; k++) begin
               if (ea[k]) begin
                  e_we = w[k]; e_addr = ad[k]; e_din = wd[k];
               end
            end
            check("m0_ack", m0_ack, ea[0]);
            check("m1_ack", m1_ack, ea[1]);
            check("ram_we", ram_we, e_we);
            check("ram_addr", ram_addr, e_addr);
            check("ram_din", ram_din, e_din);
            check("m0_rvalid", m0_rvalid, pv[0]);
            check("m1_rvalid", m1_rvalid, pv[1]);
            check("m0_rdata", m0_rdata, pv[0] ? pd[0] : 8'h00);
            check("m1_rdata", m1_rdata, pv[1] ? pd[1] : 8'h00);
            if (m0_ack) begin log_who.push_back(0); log_cyc.push_back(cyc); end
            if (m1_ack) begin log_who.push_back(1); log_cyc.push_back(cyc); end
            for (int k = 0; k < 2; k++) begin
               pv[k] = ea[k] && !w[k];
               if (ea[k] && w[k]) bmem[ad[k]] = wd[k];
               if (pv[k]) pd[k] = bmem[ad[k]];
            end
            if (own < 0) begin
               served = 0;
               if (r[0] && r[1]) begin
`ifdef RAM_ARB_RR_EN
                  own = 1 - last;
`else
                  own = 0;
`endif
               end else if (r[0]) own = 0;
               else if (r[1]) own = 1;
            end else begin
               oth = 1 - own;
               if (ea[own]) served++;
               if (!r[own] || (r[oth] && served >= MAXH)) begin
                  last = own;
                  own = r[oth] ? oth : -1;
                  served = 0;
               end
            end
         end
      end
   end

   task automatic wait_ack(input int who, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!((who == 0) ? m0_ack : m1_ack) && n < budget);
      if (!((who == 0) ? m0_ack : m1_ack)) timeout("wait_ack");
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || m0_req || m1_req) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) timeout("drain");
      repeat (3) @(negedge clk);
   endtask

   task automatic build_runs(input int mark);
      runs_who.delete(); runs_len.delete(); runs_start.delete(); runs_end.delete();
      for (int i = mark; i < log_who.size(); i++) begin
         if (runs_who.size() == 0 || runs_who[runs_who.size()-1] != log_who[i]) begin
            runs_who.push_back(log_who[i]);
            runs_len.push_back(1);
            runs_start.push_back(log_cyc[i]);
            runs_end.push_back(log_cyc[i]);
         end else begin
            runs_len[runs_len.size()-1] += 1;
            runs_end[runs_end.size()-1] = log_cyc[i];
         end
      end
   endtask

   initial begin : stim
      int mark, bubble, n, cnt, winner, exp_winner;
      #12;
      check("rst_m0_ack", m0_ack, 0);
      check("rst_m1_ack", m1_ack, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      #11 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single write: one arbitration bubble, then the ack drives the RAM.
      q0.push_back(mk(1'b1, 8'h10, 8'hA5));
      bubble = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (m0_req && !m0_ack) bubble++;
      end while (!m0_ack && n < 20);
      if (!m0_ack) timeout("first_write");
      check("first_bubble", bubble, 1);
      check("first_ram_we", ram_we, 1);
      check("first_ram_addr", ram_addr, 8'h10);
      check("first_ram_din", ram_din, 8'hA5);
      drain(50);

      q0.push_back(mk(1'b0, 8'h10, 8'h00));
      wait_ack(0, 20);
      @(negedge clk);
      check("readback_rvalid", m0_rvalid, 1);
      check("readback_rdata", m0_rdata, 8'hA5);
      drain(50);

      // Tie from IDLE with last owner m0.
      q0.push_back(mk(1'b1, 8'h31, 8'h11));
      q1.push_back(mk(1'b1, 8'h32, 8'h22));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m0_ack || m1_ack) && n < 20);
      if (!(m0_ack || m1_ack)) timeout("tie");
      winner = m1_ack ? 1 : 0;
`ifdef RAM_ARB_RR_EN
      exp_winner = 1;
`else
      exp_winner = 0;
`endif
      check("tie_winner", winner, exp_winner);
      drain(50);

      // Both stream 20 writes: bounded holds with zero-bubble handovers.
      mark = log_who.size();
      for (int i = 0; i < 20; i++) begin
         q0.push_back(mk(1'b1, 8'h40 + 8'(i), 8'(i)));
         q1.push_back(mk(1'b1, 8'h80 + 8'(i), 8'h80 | 8'(i)));
      end
      drain(200);
      build_runs(mark);
      if (runs_who.size() >= 3) begin
         check("hold_run0_len", runs_len[0], MAXH);
         check("hold_run1_len", runs_len[1], MAXH);
         check("hold_run1_owner", runs_who[1], 1 - runs_who[0]);
         check("handover_gap0", runs_start[1] - runs_end[0], 1);
         check("handover_gap1", runs_start[2] - runs_end[1], 1);
         check("regain_owner", runs_who[2], runs_who[0]);
      end else begin
         check("hold_run_count", runs_who.size(), 4);
      end

      // m1 alone streaming 40 reads: never forced off.
      mark = log_who.size();
      for (int i = 0; i < 40; i++) q1.push_back(mk(1'b0, 8'h40 + 8'(i % 20), 8'h00));
      drain(200);
      cnt = 0;
      for (int i = mark; i < log_who.size(); i++) if (log_who[i] == 1) cnt++;
      check("stream_acks", cnt, 40);
      check("stream_total", log_who.size() - mark, 40);
      if (log_who.size() > mark)
         check("stream_span", log_cyc[log_cyc.size()-1] - log_cyc[mark], 39);

      // Read on the final cycle of an m0 grant, m1 waiting.
      for (int i = 0; i < 20; i++)
         q0.push_back((i == 15) ? mk(1'b0, 8'h10, 8'h00) : mk(1'b1, 8'h20 + 8'(i), 8'h5A));
      wait_ack(0, 20);
      q1.push_back(mk(1'b0, 8'h41, 8'h00));
      cnt = 1; n = 0;
      while (cnt < MAXH && n < 100) begin
         @(negedge clk);
         n++;
         if (m0_ack) cnt++;
      end
      if (cnt < MAXH) timeout("last_grant");
      check("last_is_read", ram_we, 0);
      check("last_addr", ram_addr, 8'h10);
      @(negedge clk);
      check("last_m0_rvalid", m0_rvalid, 1);
      check("last_m0_rdata", m0_rdata, 8'hA5);
      check("last_m1_ack", m1_ack, 1);
      check("last_m1_rvalid", m1_rvalid, 0);
      drain(100);

      // Reset right after an m1 read ack drops the pending rvalid.
      q1.push_back(mk(1'b0, 8'h10, 8'h00));
      wait_ack(1, 20);
      #2 rst_n = 1'b0;
      #1;
      check("arst_m1_ack", m1_ack, 0);
      check("arst_ram_addr", ram_addr, 0);
      check("arst_m1_rvalid", m1_rvalid, 0);
      @(posedge clk);
      #1;
      check("arst_hold_rvalid", m1_rvalid, 0);
      check("arst_m1_rdata", m1_rdata, 0);
      check("arst_ram_we", ram_we, 0);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_m1_ack", m1_ack, 0);
      check("post_rst_m1_rvalid", m1_rvalid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one RAM (registered read, 1-cycle read latency, single address bus for read and write) between two requesters.
- m0 is the DEPP bridge side (depp_mem); m1 is an internal client, e.g. a pattern generator or DMA.
- Grants ownership through a 3-state FSM with a bounded hold counter, and drives the RAM we/addr/din.
- Returns read data with a valid strobe to the owning requester.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- MAX_HOLD, 16, maximum accepted accesses per grant while the other requester waits; must be >=1.
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m0_req  in  1  m0 requests an access this cycle.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  m0 address.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_ack  out  1  m0 access issued to the RAM this cycle (combinational).
- m0_rvalid  out  1  m0 read data valid (registered).
- m0_rdata  out  DATA_WIDTH  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: same as m0, for requester 1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address (read and write share it).
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after the address.

Behaviour:
- Reset values:
  - state=IDLE, hold_cnt=0, last_owner=1.
  - m0_rvalid=m1_rvalid=0; m*_rdata=0.
  - m*_ack=0, ram_we=0, ram_addr=0, ram_din=0.
- FSM states IDLE, OWN0, OWN1. The state is registered; the acks and RAM drive are decoded combinationally from state and req.
- IDLE:
  - No ack; ram_we=0; ram_addr/ram_din=0.
  - m0_req only -> OWN0. m1_req only -> OWN1.
  - Both -> OWN0 (fixed priority; see optional feature).
  - The arbitration bubble costs 1 cycle on the first access.
- OWNx with mx_req=1:
  - ram_we=mx_we, ram_addr=mx_addr, ram_din=mx_wdata, mx_ack=1, hold_cnt++.
- OWNx with mx_req=0: no ack, ram_we=0; release on this edge.
- Release condition, evaluated on each edge in OWNx: mx_req=0, OR (other_req=1 AND hold_cnt+ack reaches MAX_HOLD).
- On release:
  - Go to OWN(other) if other_req=1 (zero-bubble handover), else IDLE.
  - hold_cnt clears; last_owner=x.
- With the other requester idle, ownership is held indefinitely; hold_cnt saturates at MAX_HOLD.
- Read return:
  - mx_rvalid <= mx_ack & ~mx_we (one-cycle registered strobe).
  - mx_rdata = ram_dout while mx_rvalid=1, else 0.
  - A read accepted on the last cycle of a grant still returns its rvalid the next cycle, to the original requester, even after the handover.
- Back-to-back accesses: one per cycle while granted. A write followed by a read to the same address in the next cycle returns the new data; this follows the RAM write-first contract.
- Never more than one ack per cycle; ram_we=1 only in a cycle with an ack.
- Reset mid-operation: everything clears immediately and pending rvalid is dropped. A requester must re-request after rst_n deasserts.
- Requesters hold req/we/addr/wdata stable until they see ack.

Optional Feature:
- Macro RAM_ARB_RR_EN.
- Defined: IDLE ties go to the requester != last_owner (round-robin).
- Undefined: IDLE ties always go to m0 (the DEPP host wins); last_owner is still kept but unused.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Default ADDR_WIDTH/DATA_WIDTH constants, shared with ram and depp_mem.
- Sub-module: none required. Optional ram_arb_hold_cnt (saturating counter with clear) if it is reused elsewhere.
- The top level instantiates ram_arbiter between depp_mem (m0) and ram.

Test Plan:
- Reset, then m0 write addr 0x10 data 0xA5 -> IDLE->OWN0 in 1 cycle; m0_ack=1 with ram_we=1, ram_addr=0x10, ram_din=0xA5. m0 read 0x10 -> m0_rvalid=1 and m0_rdata=0xA5 one cycle after ack.
- m0_req and m1_req both rise from IDLE:
  - RR undefined: m0 granted first.
  - RR defined with last_owner=0: m1 granted first.
- m0 requests continuously while m1 waits (MAX_HOLD=16) -> exactly 16 m0 acks, then m1_ack the next cycle with no idle bubble; m0 regains the grant after 16 m1 acks.
- m1 only, streaming 40 reads -> 40 consecutive acks, no forced release; rvalid tracks each ack with 1-cycle delay.
- rst_n pulsed low in the cycle after an m1 read ack -> m1_rvalid stays 0, all outputs 0 asynchronously, state=IDLE.
- Read accepted on the final cycle of an m0 grant -> m0_rvalid=1 next cycle while m1_ack=1 in that same cycle; m1_rvalid stays 0 then.
